led_display_driver_phy: RTL and testbench
=========================================

# led_display_driver_phy

Physical-layer driver for a HUB75-style RGB LED matrix panel (default 64×32, 1/16 scan). It accepts one double-row of 1-bit RGB pixel data at a time (upper and lower panel halves) over a valid/ready handshake. It serialises that data on a divided bit clock, then drives row address, latch and blanking. It sits between the pattern/PWM generators and the panel connector.

## Interface
Parameters:
- SYS_CLK_FREQ, 100_000_000: system clock frequency in Hz.
- NUM_ROW_PIXELS, 32: panel rows. Must be even.
- NUM_COL_PIXELS, 64: panel columns.
- BCLK_FREQ, 25_000_000: bit clock frequency. DIV = SYS_CLK_FREQ/BCLK_FREQ must be an even integer ≥ 2.

Derived: ADDR_W = $clog2(NUM_ROW_PIXELS/2).

Ports (one clock; reset asynchronous, active-low):
- clk_in  in  1  system clock.
- n_reset_in  in  1  asynchronous active-low reset.
- rgb_upper_in  in  3*NUM_COL_PIXELS  upper-half row. Pixel c: bit 3c = R, 3c+1 = G, 3c+2 = B.
- rgb_lower_in  in  3*NUM_COL_PIXELS  lower-half row, same layout.
- valid_in  in  1  row data valid.
- ready_out  out  1  driver can accept a row.
- row_out  out  ADDR_W  address the next accepted row will be displayed on.
- bclk_out  out  1  panel shift clock.
- rgb_top_out  out  3  {B,G,R} serial data, upper half.
- rgb_bot_out  out  3  {B,G,R} serial data, lower half.
- addr_out  out  ADDR_W  panel row address.
- latch_out  out  1  panel latch strobe, active high.
- blank_out  out  1  panel output-enable, high = blanked.

## Operation
- FSM states: IDLE → SHIFT → BLANK → LATCH → IDLE.
- IDLE: ready_out = 1. On valid_in & ready_out, capture both rows into shift registers and go to SHIFT. valid_in is ignored in all other states.
- SHIFT lasts NUM_COL_PIXELS × DIV cycles and emits columns 0 → NUM_COL_PIXELS-1.
  - Each bit period: bclk_out low for DIV/2 cycles, then high for DIV/2.
  - RGB outputs change only on the first cycle of the low phase, so data is stable at the rising edge.
- BLANK lasts DIV cycles. blank_out = 1, addr_out ← internal row counter, bclk_out = 0.
- LATCH lasts DIV cycles. latch_out = 1, blank_out = 1.
- On exit to IDLE: latch_out = 0, blank_out = 0 (row lit), row counter += 1.
  - The counter wraps from NUM_ROW_PIXELS/2-1 to 0.
  - row_out shows the counter value.
- The display stays lit (blank_out = 0) while the next row shifts.

## Timing
- Reset values: ready_out 1, row_out 0, bclk_out 0, rgb_top_out/rgb_bot_out 0, addr_out 0, latch_out 0, blank_out 1. Blanked until the first latch completes.
- Handshake at cycle 0:
  - ready_out = 0 from cycle 1.
  - Column 0 data appears on rgb outputs at cycle 1; first bclk rise at cycle 1+DIV/2.
  - BLANK starts at cycle 1+NUM_COL_PIXELS·DIV; LATCH starts DIV cycles later.
  - ready_out = 1 and blank_out = 0 at cycle 1+(NUM_COL_PIXELS+2)·DIV. Defaults: cycle 1, 257, 261, 265.
- Back-to-back: valid_in held high gives a new transfer on the first IDLE cycle. Row period = (NUM_COL_PIXELS+2)·DIV+1 cycles.
- rgb outputs hold their last value after SHIFT; bclk_out stays 0 outside SHIFT.
- Reset mid-operation: all outputs return to reset values immediately, the FSM goes to IDLE and the row counter goes to 0.

## Structure
- Package led_display_pkg: NUM_ROW_PIXELS/NUM_COL_PIXELS defaults, the state enum, and the RGB bit-index constants (R=0, G=1, B=2).
- Sub-module led_display_bclk_gen:
  - Enable-gated divide-by-DIV counter.
  - Produces bclk_out, a fall strobe (shift next bit) and a period-done strobe.
- Top level holds the FSM, the 2 × 3·NUM_COL_PIXELS shift registers, and the column and row counters.

## Test plan
- Reset: hold n_reset_in low 100 ns → ready_out = 1, blank_out = 1, addr_out = 0, latch_out = 0, bclk_out = 0.
- Single row, upper all R (pattern 3'b001 repeated), lower all B → exactly 64 bclk rises at 25 MHz (40 ns period); rgb_top_out = 3'b001 and rgb_bot_out = 3'b100 at every rise; latch_out high for 40 ns; blank_out falls at cycle 265.
- Column ordering: upper row with only pixel 0 = G and pixel 63 = B → 3'b010 sampled at bclk rise 1, 3'b100 at rise 64, 0 elsewhere.
- Address wrap: 17 back-to-back rows → addr_out sequence 0, 1, …, 15, 0; row period 265 cycles; row_out leads addr_out by one.
- valid_in pulses during SHIFT → ignored: no extra bclk, and the captured data is unchanged.
- Reset asserted mid-SHIFT (cycle 100) → outputs return to reset values at once; the next transfer starts at addr 0.

Source files
------------

// File: rtl/led_display_pkg.sv
// rtl/led_display_pkg.sv - shared constants and state type for the HUB75 panel driver
package led_display_pkg;

    localparam int DEF_NUM_ROW_PIXELS = 32;
    localparam int DEF_NUM_COL_PIXELS = 64;

    // Bit positions of one pixel inside the packed row and the serial outputs
    localparam int RGB_R = 0;
    localparam int RGB_G = 1;
    localparam int RGB_B = 2;
    localparam int PIX_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_BLANK = 2'd2,
        ST_LATCH = 2'd3
    } led_state_e;

endpackage

// File: rtl/led_display_bclk_gen.sv
// rtl/led_display_bclk_gen.sv - enable-gated divide-by-DIV bit clock and period strobes
module led_display_bclk_gen #(
    parameter int DIV = 4
) (
    input  logic clk_in,
    input  logic n_reset_in,
    input  logic en_in,
    input  logic bclk_en_in,
    output logic bclk_out,
    output logic fall_stb_out,
    output logic done_stb_out
);

    localparam int PH_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PH_W-1:0] PH_HALF = PH_W'(DIV / 2);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DIV - 1);

    logic [PH_W-1:0] phase_q;
    logic [PH_W-1:0] phase_d;

    // Phase is held at zero while disabled so every period starts with a full low half
    always_comb begin
        phase_d = phase_q;
        if (!en_in) begin
            phase_d = '0;
        end else if (phase_q == PH_LAST) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign done_stb_out = en_in && (phase_q == PH_LAST);
    assign fall_stb_out = done_stb_out && bclk_en_in;
    assign bclk_out     = en_in && bclk_en_in && (phase_q >= PH_HALF);

endmodule

// File: rtl/led_display_driver_phy.sv
// rtl/led_display_driver_phy.sv - HUB75 row serialiser with address, latch and blanking control
module led_display_driver_phy
    import led_display_pkg::*;
#(
    parameter int SYS_CLK_FREQ   = 100_000_000,
    parameter int NUM_ROW_PIXELS = DEF_NUM_ROW_PIXELS,
    parameter int NUM_COL_PIXELS = DEF_NUM_COL_PIXELS,
    parameter int BCLK_FREQ      = 25_000_000,
    localparam int ADDR_W        = $clog2(NUM_ROW_PIXELS / 2)
) (
    input  logic                          clk_in,
    input  logic                          n_reset_in,
    input  logic [3*NUM_COL_PIXELS-1:0]   rgb_upper_in,
    input  logic [3*NUM_COL_PIXELS-1:0]   rgb_lower_in,
    input  logic                          valid_in,
    output logic                          ready_out,
    output logic [ADDR_W-1:0]             row_out,
    output logic                          bclk_out,
    output logic [2:0]                    rgb_top_out,
    output logic [2:0]                    rgb_bot_out,
    output logic [ADDR_W-1:0]             addr_out,
    output logic                          latch_out,
    output logic                          blank_out
);

    localparam int DIV   = SYS_CLK_FREQ / BCLK_FREQ;
    localparam int ROW_W = PIX_W * NUM_COL_PIXELS;
    localparam int COL_W = (NUM_COL_PIXELS > 2) ? $clog2(NUM_COL_PIXELS) : 1;
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(NUM_COL_PIXELS - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(NUM_ROW_PIXELS / 2 - 1);

    led_state_e        state_q,   state_d;
    logic [ROW_W-1:0]  sh_top_q,  sh_top_d;
    logic [ROW_W-1:0]  sh_bot_q,  sh_bot_d;
    logic [PIX_W-1:0]  rgb_top_q, rgb_top_d;
    logic [PIX_W-1:0]  rgb_bot_q, rgb_bot_d;
    logic [COL_W-1:0]  col_q,     col_d;
    logic [ADDR_W-1:0] row_q,     row_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic              blank_q,   blank_d;

    logic fall_stb;
    logic done_stb;

    led_display_bclk_gen #(
        .DIV (DIV)
    ) u_bclk_gen (
        .clk_in       (clk_in),
        .n_reset_in   (n_reset_in),
        .en_in        (state_q != ST_IDLE),
        .bclk_en_in   (state_q == ST_SHIFT),
        .bclk_out     (bclk_out),
        .fall_stb_out (fall_stb),
        .done_stb_out (done_stb)
    );

    always_comb begin
        state_d   = state_q;
        sh_top_d  = sh_top_q;
        sh_bot_d  = sh_bot_q;
        rgb_top_d = rgb_top_q;
        rgb_bot_d = rgb_bot_q;
        col_d     = col_q;
        row_d     = row_q;
        addr_d    = addr_q;
        blank_d   = blank_q;
        case (state_q)
            ST_IDLE: begin
                // Column 0 goes straight to the pins; the rest waits in the shifters
                if (valid_in) begin
                    state_d   = ST_SHIFT;
                    rgb_top_d = rgb_upper_in[PIX_W-1:0];
                    rgb_bot_d = rgb_lower_in[PIX_W-1:0];
                    sh_top_d  = rgb_upper_in >> PIX_W;
                    sh_bot_d  = rgb_lower_in >> PIX_W;
                    col_d     = '0;
                end
            end
            ST_SHIFT: begin
                if (fall_stb) begin
                    if (col_q == COL_LAST) begin
                        state_d = ST_BLANK;
                        blank_d = 1'b1;
                        addr_d  = row_q;
                    end else begin
                        col_d     = col_q + 1'b1;
                        rgb_top_d = sh_top_q[PIX_W-1:0];
                        rgb_bot_d = sh_bot_q[PIX_W-1:0];
                        sh_top_d  = sh_top_q >> PIX_W;
                        sh_bot_d  = sh_bot_q >> PIX_W;
                    end
                end
            end
            ST_BLANK: begin
                if (done_stb) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (done_stb) begin
                    state_d = ST_IDLE;
                    blank_d = 1'b0;
                    row_d   = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            state_q   <= ST_IDLE;
            sh_top_q  <= '0;
            sh_bot_q  <= '0;
            rgb_top_q <= '0;
            rgb_bot_q <= '0;
            col_q     <= '0;
            row_q     <= '0;
            addr_q    <= '0;
            blank_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            sh_top_q  <= sh_top_d;
            sh_bot_q  <= sh_bot_d;
            rgb_top_q <= rgb_top_d;
            rgb_bot_q <= rgb_bot_d;
            col_q     <= col_d;
            row_q     <= row_d;
            addr_q    <= addr_d;
            blank_q   <= blank_d;
        end
    end

    assign ready_out   = (state_q == ST_IDLE);
    assign latch_out   = (state_q == ST_LATCH);
    assign blank_out   = blank_q;
    assign row_out     = row_q;
    assign addr_out    = addr_q;
    assign rgb_top_out = rgb_top_q;
    assign rgb_bot_out = rgb_bot_q;

endmodule

// File: tb/tb_led_display_driver_phy.sv
// tb/tb_led_display_driver_phy.sv - self-checking bench for the HUB75 row driver
module tb_led_display_driver_phy;
    import led_display_pkg::*;

    localparam int N         = 64;
    localparam int ROWS      = 32;
    localparam int HALF_ROWS = ROWS / 2;
    localparam int DIV       = 4;
    localparam int END_K     = (N + 2) * DIV + 1;

    logic           clk = 1'b0;
    logic           n_reset_in;
    logic [3*N-1:0] rgb_upper_in;
    logic [3*N-1:0] rgb_lower_in;
    logic           valid_in;
    logic           ready_out;
    logic [3:0]     row_out;
    logic           bclk_out;
    logic [2:0]     rgb_top_out;
    logic [2:0]     rgb_bot_out;
    logic [3:0]     addr_out;
    logic           latch_out;
    logic           blank_out;

    always #5 clk = ~clk;

    led_display_driver_phy dut (
        .clk_in       (clk),
        .n_reset_in   (n_reset_in),
        .rgb_upper_in (rgb_upper_in),
        .rgb_lower_in (rgb_lower_in),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .row_out      (row_out),
        .bclk_out     (bclk_out),
        .rgb_top_out  (rgb_top_out),
        .rgb_bot_out  (rgb_bot_out),
        .addr_out     (addr_out),
        .latch_out    (latch_out),
        .blank_out    (blank_out)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: outputs follow from the cycle offset since the accepted handshake
    bit             m_busy;
    int             m_t0;
    logic [3*N-1:0] m_up, m_lo;
    int             m_row;
    bit             m_lit;
    int             m_addr;
    logic [2:0]     m_top, m_bot;

    always @(negedge clk) begin : model_cmp
        int k, c, ph;
        logic e_ready, e_bclk, e_latch, e_blank;
        if (!n_reset_in) begin
            m_busy = 0; m_row = 0; m_lit = 0; m_addr = 0; m_top = '0; m_bot = '0;
        end else if (m_busy && (cyc - m_t0 == END_K)) begin
            m_busy = 0;
            m_row  = (m_row + 1) % HALF_ROWS;
            m_lit  = 1;
        end
        e_ready = !m_busy;
        e_bclk  = 1'b0;
        e_latch = 1'b0;
        e_blank = !m_lit;
        if (m_busy) begin
            k = cyc - m_t0;
            if (k <= N * DIV) begin
                c      = (k - 1) / DIV;
                ph     = (k - 1) % DIV;
                e_bclk = (ph >= DIV / 2);
                m_top  = m_up[3*c +: 3];
                m_bot  = m_lo[3*c +: 3];
            end else begin
                m_addr  = m_row;
                e_blank = 1'b1;
                e_latch = (k > N * DIV + DIV);
            end
        end
        chk("ready",   ready_out,   e_ready);
        chk("row",     row_out,     m_row);
        chk("bclk",    bclk_out,    e_bclk);
        chk("rgb_top", rgb_top_out, m_top);
        chk("rgb_bot", rgb_bot_out, m_bot);
        chk("addr",    addr_out,    m_addr);
        chk("latch",   latch_out,   e_latch);
        chk("blank",   blank_out,   e_blank);
        if (n_reset_in && !m_busy && valid_in) begin
            m_busy = 1;
            m_t0   = cyc;
            m_up   = rgb_upper_in;
            m_lo   = rgb_lower_in;
        end
    end

    // Event log used by the directed literal checks
    int         rise_cnt, latch_cycles, blank_fall_cyc;
    logic [2:0] rise_top[$];
    logic [2:0] rise_bot[$];
    int         rise_cyc[$];
    int         hs_cyc[$];
    int         addr_log[$];
    int         row_after[$];
    logic       p_bclk = 0, p_latch = 0, p_blank = 1, p_ready = 1;

    always @(negedge clk) begin
        if (bclk_out && !p_bclk) begin
            rise_cnt++;
            rise_top.push_back(rgb_top_out);
            rise_bot.push_back(rgb_bot_out);
            rise_cyc.push_back(cyc);
        end
        if (latch_out) latch_cycles++;
        if (latch_out && !p_latch) addr_log.push_back(int'(addr_out));
        if (!blank_out && p_blank) blank_fall_cyc = cyc;
        if (ready_out && !p_ready && n_reset_in) row_after.push_back(int'(row_out));
        if (n_reset_in && valid_in && ready_out) hs_cyc.push_back(cyc);
        p_bclk  = bclk_out;
        p_latch = latch_out;
        p_blank = blank_out;
        p_ready = ready_out;
    end

    task automatic clear_log();
        rise_cnt = 0; latch_cycles = 0; blank_fall_cyc = -1;
        rise_top.delete(); rise_bot.delete(); rise_cyc.delete();
        hs_cyc.delete(); addr_log.delete(); row_after.delete();
    endtask

    task automatic send_row(input logic [3*N-1:0] up, input logic [3*N-1:0] lo);
        int n;
        n = 0;
        @(posedge clk); #2;
        rgb_upper_in = up;
        rgb_lower_in = lo;
        valid_in     = 1'b1;
        forever begin
            @(negedge clk);
            if (ready_out) break;
            n++;
            if (n > 2000) begin
                chk("send_timeout", 1, 0);
                break;
            end
        end
        @(posedge clk); #2;
        valid_in = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (ready_out) break;
            n++;
            if (n > 2000) begin
                chk("idle_timeout", 1, 0);
                break;
            end
        end
        @(posedge clk); #2;
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk); #2;
        n_reset_in = 1'b0;
        valid_in   = 1'b0;
        repeat (cycles) @(posedge clk);
        #2 n_reset_in = 1'b1;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3*N-1:0] up, lo, alt;
        logic [2:0]     px;
        int             bad, bad2, n;
        n_reset_in   = 1'b0;
        valid_in     = 1'b0;
        rgb_upper_in = '0;
        rgb_lower_in = '0;
        clear_log();

        // Reset held for 100 ns
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", ready_out, 1);
        chk("rst_blank", blank_out, 1);
        chk("rst_addr",  addr_out,  0);
        chk("rst_latch", latch_out, 0);
        chk("rst_bclk",  bclk_out,  0);
        @(posedge clk); #2 n_reset_in = 1'b1;

        // Single row: upper all red, lower all blue
        clear_log();
        send_row({N{3'b001}}, {N{3'b100}});
        wait_idle();
        chk("t1_rises", rise_cnt, 64);
        bad = 0; bad2 = 0;
        foreach (rise_top[i]) begin
            if (rise_top[i] !== 3'b001) bad++;
            if (rise_bot[i] !== 3'b100) bad2++;
        end
        chk("t1_top_at_rise", bad, 0);
        chk("t1_bot_at_rise", bad2, 0);
        bad = 0;
        for (int i = 1; i < rise_cyc.size(); i++) if (rise_cyc[i] - rise_cyc[i-1] != 4) bad++;
        chk("t1_bclk_period", bad, 0);
        chk("t1_latch_len", latch_cycles, 4);
        chk("t1_blank_fall", blank_fall_cyc - hs_cyc[0], 265);

        // Column ordering: only pixel 0 green (top) and pixel 63 blue
        clear_log();
        up = '0;
        px = '0; px[RGB_G] = 1'b1; up[2:0] = px;
        px = '0; px[RGB_B] = 1'b1; up[3*63 +: 3] = px;
        lo = {32{6'b101_011}};
        send_row(up, lo);
        wait_idle();
        chk("t2_rises", rise_cnt, 64);
        chk("t2_rise1", rise_top[0], 3'b010);
        chk("t2_rise64", rise_top[63], 3'b100);
        bad = 0;
        for (int i = 1; i < 63; i++) if (rise_top[i] !== 3'b000) bad++;
        chk("t2_middle_zero", bad, 0);

        // valid_in pulses while shifting are ignored
        clear_log();
        for (int i = 0; i < N; i++) begin
            up[3*i +: 3] = 3'($urandom_range(7));
            lo[3*i +: 3] = 3'($urandom_range(7));
        end
        alt = ~up;
        send_row(up, lo);
        for (int p = 0; p < 5; p++) begin
            repeat (20) @(posedge clk);
            #2 rgb_upper_in = alt; rgb_lower_in = ~lo; valid_in = 1'b1;
            @(posedge clk); #2 valid_in = 1'b0;
        end
        wait_idle();
        chk("t3_rises", rise_cnt, 64);
        chk("t3_handshakes", hs_cyc.size(), 1);
        bad = 0;
        foreach (rise_top[i]) if (rise_top[i] !== up[3*i +: 3]) bad++;
        chk("t3_data_kept", bad, 0);

        // Address wrap over 17 back-to-back rows
        do_reset(3);
        clear_log();
        @(posedge clk); #2;
        rgb_upper_in = {N{3'b011}};
        rgb_lower_in = {N{3'b110}};
        valid_in     = 1'b1;
        n = 0;
        for (int t = 0; t < 6000 && n < 17; t++) begin
            @(negedge clk);
            if (ready_out) n++;
        end
        chk("t4_got_17", n, 17);
        @(posedge clk); #2 valid_in = 1'b0;
        wait_idle();
        chk("t4_addr_count", addr_log.size(), 17);
        bad = 0;
        foreach (addr_log[i]) if (addr_log[i] != i % 16) bad++;
        chk("t4_addr_seq", bad, 0);
        chk("t4_addr_last", addr_log[16], 0);
        bad = 0;
        for (int i = 1; i < hs_cyc.size(); i++) if (hs_cyc[i] - hs_cyc[i-1] != 265) bad++;
        chk("t4_row_period", bad, 0);
        bad = 0;
        foreach (row_after[i]) if (row_after[i] != (addr_log[i] + 1) % 16) bad++;
        chk("t4_row_leads", bad, 0);

        // Reset during SHIFT at cycle 100 after the handshake
        send_row({N{3'b111}}, {N{3'b101}});
        repeat (99) @(posedge clk);
        #2 n_reset_in = 1'b0;
        @(negedge clk);
        chk("t5_ready", ready_out, 1);
        chk("t5_blank", blank_out, 1);
        chk("t5_bclk",  bclk_out,  0);
        chk("t5_latch", latch_out, 0);
        chk("t5_addr",  addr_out,  0);
        chk("t5_row",   row_out,   0);
        chk("t5_rgb",   {rgb_top_out, rgb_bot_out}, 6'd0);
        @(posedge clk); #2 n_reset_in = 1'b1;
        clear_log();
        send_row({N{3'b010}}, {N{3'b001}});
        wait_idle();
        chk("t5_next_addr", addr_log.size() == 1 ? addr_log[0] : -1, 0);
        chk("t5_next_row", row_out, 1);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
